// File: rtl/frame_buf_pkg.sv
// Shared frame-buffer layout and writer state encoding; the VGA reader imports
// this same package so both sides agree on geometry and base addresses.
package frame_buf_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_FRAME,
    ST_WAIT_DATA,
    ST_REQ,
    ST_BURST,
    ST_FRAME_DONE
  } wr_state_t;

  localparam int IMG_WIDTH  = 320;
  localparam int IMG_HEIGHT = 240;
  localparam int IMG_SIZE   = IMG_WIDTH * IMG_HEIGHT;
  localparam int BURST_LEN  = 8;

  localparam logic [23:0] BASE_ADDR0 = 24'h000000;
  localparam logic [23:0] BASE_ADDR1 = 24'h020000;

endpackage

// File: rtl/sdram_frame_writer_burst_addr_gen.sv
// Burst counter and frame base selection for the SDRAM frame writer.
// Ping-pong buffering is enabled by SDRAM_FRAME_WRITER_DOUBLE_BUFFER_EN.
module burst_addr_gen #(
  parameter int                    ADDR_WIDTH = 24,
  parameter int                    BURST_LEN  = 8,
  parameter int                    NUM_BURSTS = 9600,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR0 = '0,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR1 = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_load,
  input  logic                  i_inc,
  input  logic                  i_frame_done,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic                  o_last,
  output logic                  o_wr_buf
);

  localparam int SHIFT = $clog2(BURST_LEN);

  logic [ADDR_WIDTH-1:0] r_base;
  logic [ADDR_WIDTH-1:0] r_burst_cnt;
  logic                  r_wr_buf;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_base      <= '0;
      r_burst_cnt <= '0;
      r_wr_buf    <= 1'b0;
    end else begin
      if (i_load) begin
        r_burst_cnt <= '0;
        r_base      <= r_wr_buf ? BASE_ADDR1 : BASE_ADDR0;
      end else if (i_inc) begin
        r_burst_cnt <= r_burst_cnt + ADDR_WIDTH'(1);
      end
`ifdef SDRAM_FRAME_WRITER_DOUBLE_BUFFER_EN
      if (i_frame_done) r_wr_buf <= ~r_wr_buf;
`else
      // Single-buffer build: every frame lands in buffer 0.
      if (i_frame_done) r_wr_buf <= 1'b0;
`endif
    end
  end

  assign o_addr   = r_base + (r_burst_cnt << SHIFT);
  assign o_last   = (r_burst_cnt == ADDR_WIDTH'(NUM_BURSTS - 1));
  assign o_wr_buf = r_wr_buf;

endmodule

// File: rtl/sdram_frame_writer.sv
// Drains the camera capture FIFO into SDRAM as fixed-length write bursts.
// Optional ping-pong buffering: SDRAM_FRAME_WRITER_DOUBLE_BUFFER_EN.
module sdram_frame_writer import frame_buf_pkg::*; #(
  parameter int                    IMG_WIDTH  = frame_buf_pkg::IMG_WIDTH,
  parameter int                    IMG_HEIGHT = frame_buf_pkg::IMG_HEIGHT,
  parameter int                    DATA_WIDTH = 16,
  parameter int                    ADDR_WIDTH = 24,
  parameter int                    BURST_LEN  = frame_buf_pkg::BURST_LEN,
  parameter int                    USED_WIDTH = 11,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR0 = ADDR_WIDTH'(frame_buf_pkg::BASE_ADDR0),
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR1 = ADDR_WIDTH'(frame_buf_pkg::BASE_ADDR1)
) (
  input  logic                  clk_sdram,
  input  logic                  rst,
  input  logic                  sdram_ready,
  input  logic                  frame_start,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  input  logic [USED_WIDTH-1:0] fifo_used,
  output logic                  fifo_rd_en,
  output logic                  sdram_wr_req,
  output logic [ADDR_WIDTH-1:0] sdram_wr_addr,
  input  logic                  sdram_wr_grant,
  input  logic                  sdram_wr_data_req,
  output logic [DATA_WIDTH-1:0] sdram_wr_data,
  output logic                  frame_done,
  output logic                  frame_ready,
  output logic                  frame_overrun,
  output logic                  buf_sel
);

  localparam int NUM_BURSTS = IMG_WIDTH * IMG_HEIGHT / BURST_LEN;
  localparam int BEAT_W     = $clog2(BURST_LEN);

  wr_state_t             r_state, w_state_nxt;
  logic [BEAT_W-1:0]     r_beat_cnt;
  logic                  r_fifo_ok;
  logic                  r_frame_ready;
  logic                  r_buf_sel;
  logic                  r_overrun;
  logic                  w_load;
  logic                  w_beat;
  logic                  w_last_beat;
  logic                  w_last_burst;
  logic                  w_wr_buf;
  logic [ADDR_WIDTH-1:0] w_addr;

  burst_addr_gen #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .BURST_LEN  (BURST_LEN),
    .NUM_BURSTS (NUM_BURSTS),
    .BASE_ADDR0 (BASE_ADDR0),
    .BASE_ADDR1 (BASE_ADDR1)
  ) u_addr (
    .clk          (clk_sdram),
    .rst          (rst),
    .i_load       (w_load),
    .i_inc        (w_last_beat),
    .i_frame_done (r_state == ST_FRAME_DONE),
    .o_addr       (w_addr),
    .o_last       (w_last_burst),
    .o_wr_buf     (w_wr_buf)
  );

  assign w_load      = (r_state == ST_WAIT_FRAME) && frame_start;
  assign w_beat      = (r_state == ST_BURST) && sdram_wr_data_req;
  assign w_last_beat = w_beat && (r_beat_cnt == BEAT_W'(BURST_LEN - 1));

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:       if (sdram_ready)    w_state_nxt = ST_WAIT_FRAME;
      ST_WAIT_FRAME: if (frame_start)    w_state_nxt = ST_WAIT_DATA;
      ST_WAIT_DATA:  if (r_fifo_ok)      w_state_nxt = ST_REQ;
      ST_REQ:        if (sdram_wr_grant) w_state_nxt = ST_BURST;
      ST_BURST:      if (w_last_beat)
                       w_state_nxt = w_last_burst ? ST_FRAME_DONE : ST_WAIT_DATA;
      ST_FRAME_DONE: w_state_nxt = ST_WAIT_FRAME;
      default:       w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_sdram) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_beat_cnt    <= '0;
      r_fifo_ok     <= 1'b0;
      r_frame_ready <= 1'b0;
      r_buf_sel     <= 1'b0;
      r_overrun     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      // Only trust the fill level sampled while waiting, so a stale pre-pop
      // level left over from the previous burst never triggers a request.
      r_fifo_ok <= (r_state == ST_WAIT_DATA) && (fifo_used >= USED_WIDTH'(BURST_LEN));
      if (w_load)      r_beat_cnt <= '0;
      else if (w_beat) r_beat_cnt <= r_beat_cnt + BEAT_W'(1);
      if (r_state == ST_FRAME_DONE) begin
        r_frame_ready <= 1'b1;
        r_buf_sel     <= w_wr_buf;
      end
      r_overrun <= frame_start && (r_state != ST_IDLE) && (r_state != ST_WAIT_FRAME);
    end
  end

  assign sdram_wr_req  = (r_state == ST_REQ);
  assign sdram_wr_addr = (r_state == ST_REQ) ? w_addr : '0;
  assign fifo_rd_en    = w_beat;
  assign sdram_wr_data = (r_state == ST_BURST) ? fifo_rd_data : '0;
  assign frame_done    = (r_state == ST_FRAME_DONE);
  assign frame_ready   = r_frame_ready;
  assign frame_overrun = r_overrun;
  assign buf_sel       = r_buf_sel;

endmodule

// File: tb/tb_sdram_frame_writer.sv
// Directed bench for sdram_frame_writer on a reduced 32x4 frame (16 bursts);
// honours SDRAM_FRAME_WRITER_DOUBLE_BUFFER_EN for the ping-pong expectations.
module tb_sdram_frame_writer;

  localparam int IW = 32, IH = 4, BL = 8, NB = IW * IH / BL;
  localparam int DW = 16, AW = 24, UW = 11;
`ifdef SDRAM_FRAME_WRITER_DOUBLE_BUFFER_EN
  localparam bit DBL = 1'b1;
`else
  localparam bit DBL = 1'b0;
`endif

  logic          clk_sdram = 1'b0;
  logic          rst = 1'b1, sdram_ready = 1'b0, frame_start = 1'b0;
  logic [DW-1:0] fifo_rd_data = '0;
  logic [UW-1:0] fifo_used = '0;
  logic          fifo_rd_en, sdram_wr_req, sdram_wr_grant = 1'b0, sdram_wr_data_req = 1'b0;
  logic [AW-1:0] sdram_wr_addr;
  logic [DW-1:0] sdram_wr_data;
  logic          frame_done, frame_ready, frame_overrun, buf_sel;

  sdram_frame_writer #(.IMG_WIDTH(IW), .IMG_HEIGHT(IH)) dut (
    .clk_sdram(clk_sdram), .rst(rst), .sdram_ready(sdram_ready), .frame_start(frame_start),
    .fifo_rd_data(fifo_rd_data), .fifo_used(fifo_used), .fifo_rd_en(fifo_rd_en),
    .sdram_wr_req(sdram_wr_req), .sdram_wr_addr(sdram_wr_addr), .sdram_wr_grant(sdram_wr_grant),
    .sdram_wr_data_req(sdram_wr_data_req), .sdram_wr_data(sdram_wr_data),
    .frame_done(frame_done), .frame_ready(frame_ready), .frame_overrun(frame_overrun),
    .buf_sel(buf_sel));

  initial forever #5 clk_sdram = ~clk_sdram;

  int checks = 0, failures = 0;
  // controller/FIFO model state
  int grant_dly = 1, gap_off = 0, req_cyc = 0, gap_cnt = 0, beats = 0;
  bit stray = 1'b0, in_burst = 1'b0;
  int burst_idx = 0, pops = 0, done_cnt = 0, ovr_cnt = 0, req_seen = 0;
  logic [DW-1:0] pix = '0;
  logic [AW-1:0] held_addr = '0, last_addr = '0, exp_base = '0;
  // per-frame snapshots
  int idx0 = 0, p0 = 0, d0 = 0, fidx = 0;

  typedef struct {
    int gdly; int gap; bit stry;
    int exp_bursts; int exp_pops; int exp_last_off;
  } vec_t;
  vec_t vecs[3];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [AW-1:0] base_for(input int k);
    return (DBL && k[0]) ? 24'h020000 : 24'h000000;
  endfunction

  // One clock: negedge -> negedge. Acts as SDRAM controller and FIFO.
  task automatic cycle();
    bit g, dr, req_now, pop;
    g = 1'b0; dr = 1'b0; req_now = sdram_wr_req;
    done_cnt += int'(frame_done);
    ovr_cnt  += int'(frame_overrun);
    if (in_burst) begin
      if (gap_cnt == 0) begin dr = 1'b1; gap_cnt = gap_off; end
      else gap_cnt--;
    end else if (stray) dr = 1'b1;
    if (req_now) begin
      req_seen++;
      if (req_cyc == 0) begin
        held_addr = sdram_wr_addr;
        chk("req_addr", sdram_wr_addr, exp_base + AW'((burst_idx - idx0) * BL));
      end else chk("addr_hold", sdram_wr_addr, held_addr);
      if (req_cyc >= grant_dly) g = 1'b1;
      req_cyc++;
    end else if (stray) g = 1'b1;
    sdram_wr_grant = g; sdram_wr_data_req = dr;
    #1;
    chk("rd_en", fifo_rd_en, dr && in_burst);
    if (fifo_rd_en) chk("wr_data", sdram_wr_data, pix);
    pop = fifo_rd_en;
    @(posedge clk_sdram); #1;
    if (pop) begin pix++; pops++; end
    fifo_rd_data = pix;
    if (rst) begin
      in_burst = 1'b0; req_cyc = 0; beats = 0; gap_cnt = 0;
    end else begin
      if (dr && in_burst) begin
        beats++;
        if (beats == BL) begin in_burst = 1'b0; beats = 0; end
      end
      if (req_now && g) begin
        in_burst = 1'b1; gap_cnt = 0; req_cyc = 0; beats = 0;
        last_addr = held_addr; burst_idx++;
      end
    end
    @(negedge clk_sdram);
  endtask

  task automatic begin_frame();
    exp_base = base_for(fidx); idx0 = burst_idx; p0 = pops; d0 = done_cnt;
    frame_start = 1'b1; cycle(); frame_start = 1'b0;
  endtask

  task automatic finish_frame(input string tag, input int eb, input int ep, input int lo);
    for (int i = 0; i < 4000 && done_cnt == d0; i++) cycle();
    chk({tag, "_done_seen"}, done_cnt != d0, 1);
    cycle(); cycle();
    chk({tag, "_bursts"}, burst_idx - idx0, eb);
    chk({tag, "_pops"}, pops - p0, ep);
    chk({tag, "_last_addr"}, last_addr, exp_base + AW'(lo));
    chk({tag, "_done_once"}, done_cnt - d0, 1);
    chk({tag, "_ready"}, frame_ready, 1);
    chk({tag, "_buf_sel"}, buf_sel, DBL ? fidx[0] : 1'b0);
    fidx++;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req"}, sdram_wr_req, 0);
    chk({tag, "_rd_en"}, fifo_rd_en, 0);
    chk({tag, "_addr"}, sdram_wr_addr, 0);
    chk({tag, "_data"}, sdram_wr_data, 0);
    chk({tag, "_done"}, frame_done, 0);
    chk({tag, "_ready"}, frame_ready, 0);
    chk({tag, "_ovr"}, frame_overrun, 0);
    chk({tag, "_buf_sel"}, buf_sel, 0);
  endtask

  initial begin
    int r0, o0;
    vecs[0] = '{gdly: 1,  gap: 0, stry: 1'b0, exp_bursts: NB, exp_pops: NB*BL, exp_last_off: 'h78};
    vecs[1] = '{gdly: 20, gap: 2, stry: 1'b0, exp_bursts: NB, exp_pops: NB*BL, exp_last_off: 'h78};
    vecs[2] = '{gdly: 0,  gap: 1, stry: 1'b1, exp_bursts: NB, exp_pops: NB*BL, exp_last_off: 'h78};

    @(negedge clk_sdram);
    rst = 1'b1; fifo_rd_data = pix; fifo_used = UW'(100);
    cycle(); cycle();
    chk_reset_outputs("por");
    rst = 1'b0;
    cycle();
    // frame_start while SDRAM not ready: silently ignored
    r0 = req_seen; o0 = ovr_cnt;
    frame_start = 1'b1; cycle(); frame_start = 1'b0;
    repeat (6) cycle();
    chk("idle_no_req", req_seen - r0, 0);
    chk("idle_no_ovr", ovr_cnt - o0, 0);
    sdram_ready = 1'b1;
    cycle();

    foreach (vecs[i]) begin
      grant_dly = vecs[i].gdly; gap_off = vecs[i].gap; stray = vecs[i].stry;
      begin_frame();
      finish_frame($sformatf("vec%0d", i), vecs[i].exp_bursts, vecs[i].exp_pops,
                   vecs[i].exp_last_off);
    end
    grant_dly = 1; gap_off = 0; stray = 1'b0;

    // FIFO threshold: 7 words never requests, 8 words requests within 2 cycles
    fifo_used = UW'(7);
    begin_frame();
    r0 = req_seen;
    repeat (30) cycle();
    chk("thr7_no_req", req_seen - r0, 0);
    fifo_used = UW'(8);
    cycle(); cycle();
    chk("thr8_req", sdram_wr_req, 1);
    fifo_used = UW'(100);
    finish_frame("thr", NB, NB*BL, 'h78);

    // frame_start mid-frame: overrun pulse, address sequence not restarted
    begin_frame();
    o0 = ovr_cnt;
    for (int i = 0; i < 400 && (burst_idx - idx0) < 3; i++) cycle();
    chk("ovr_reach_b3", burst_idx - idx0, 3);
    frame_start = 1'b1; cycle(); frame_start = 1'b0;
    chk("ovr_pulse", frame_overrun, 1);
    cycle();
    chk("ovr_pulse_end", frame_overrun, 0);
    for (int i = 0; i < 400 && (burst_idx - idx0) < 4; i++) cycle();
    chk("ovr_next_addr", last_addr, exp_base + AW'('h18));
    finish_frame("ovr", NB, NB*BL, 'h78);
    chk("ovr_count", ovr_cnt - o0, 1);

    // reset in the middle of a burst (after 4 beats)
    begin_frame();
    for (int i = 0; i < 400 && (pops - p0) < 4; i++) cycle();
    chk("rst_reach_beat4", pops - p0, 4);
    rst = 1'b1; cycle();
    chk_reset_outputs("mid_rst");
    rst = 1'b0; fidx = 0;
    cycle(); cycle();
    begin_frame();
    finish_frame("post_rst", NB, NB*BL, 'h78);
    // second frame after reset exercises the other buffer when ping-pong is on
    begin_frame();
    finish_frame("post_rst2", NB, NB*BL, 'h78);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
